// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB3 master port among NUM_REQ requesters.
// Optional ACCESS-phase timeout: define APB_ARB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                ACLK,
  input  logic                                ARESETn,
  input  logic [NUM_REQ-1:0]                  req_i,
  input  logic [NUM_REQ-1:0]                  we_i,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]                  gnt_o,
  output logic [NUM_REQ-1:0]                  rsp_valid_o,
  output logic [APB_DATA_WIDTH-1:0]           rsp_rdata_o,
  output logic                                rsp_err_o,
  output logic                                PSEL,
  output logic                                PENABLE,
  output logic                                PWRITE,
  output logic [APB_ADDR_WIDTH-1:0]           PADDR,
  output logic [APB_DATA_WIDTH-1:0]           PWDATA,
  input  logic [APB_DATA_WIDTH-1:0]           PRDATA,
  input  logic                                PREADY,
  input  logic                                PSLVERR
);

  localparam int AW = APB_ADDR_WIDTH;
  localparam int DW = APB_DATA_WIDTH;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      win;
  logic [IW-1:0]      owner;
  logic               found;
  logic [AW-1:0]      addr_q;
  logic               we_q;
  logic [DW-1:0]      wdata_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DW-1:0]      rdata_q;
  logic               err_q;
  logic               done;
  logic               tout;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    int s;
    found = 1'b0;
    win   = '0;
    s     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s = int'(ptr) + i;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      if (!found && req_i[IW'(s)]) begin
        found = 1'b1;
        win   = IW'(s);
      end
    end
  end

  // Grant pulse only while idle and out of reset.
  always_comb begin
    gnt_o = '0;
    if (ARESETn && state == IDLE && found)
      gnt_o[win] = 1'b1;
  end

`ifdef APB_ARB_TIMEOUT_EN
  logic [15:0] cnt;
  logic        limit;

  assign limit = (cnt == 16'(TIMEOUT_CYCLES - 1));

  // Counts ACCESS wait cycles; restarts on entry to ACCESS.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)
      cnt <= '0;
    else if (state == SETUP)
      cnt <= '0;
    else if (state == ACCESS && !PREADY)
      cnt <= cnt + 16'd1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  // Next-state logic and completion events.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    tout      = 1'b0;
    case (state)
      IDLE: begin
        if (found) state_nxt = SETUP;
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (limit) begin
          tout      = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Latch the winner's transfer and advance the pointer.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ptr     <= '0;
      owner   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (state == IDLE && found) begin
      ptr     <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      owner   <= win;
      addr_q  <= addr_i[int'(win)*AW +: AW];
      we_q    <= we_i[win];
      wdata_q <= wdata_i[int'(win)*DW +: DW];
    end
  end

  // One-cycle response pulse after completion or abort.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      if (done || tout) begin
        rsp_valid_q[owner] <= 1'b1;
        rdata_q <= (done && !we_q) ? PRDATA : '0;
        err_q   <= done ? PSLVERR : 1'b1;
      end
    end
  end

  assign PSEL        = (state != IDLE);
  assign PENABLE     = (state == ACCESS);
  assign PWRITE      = we_q;
  assign PADDR       = addr_q;
  assign PWDATA      = wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule
